// File: rtl/clk_activity_monitor.sv
// clk_activity_monitor
// Multi-channel clock activity and frequency monitor. Every channel gets a
// free-running binary counter of a monitored clock that has already been
// brought into the clk domain. Each channel reports:
//   - whether the counter moved in the recent past (toggling);
//   - a sticky loss flag that sets when toggling drops (lost);
//   - the number of counter increments seen over a programmable gate window
//     (freq), and whether that count is inside shared limits (in_range).
//
// Ports:
//   clk        - the single clock; all logic runs on its rising edge
//   rst        - synchronous, active-high reset
//   cnt_in     - per-channel synchronized counters, channel i at [i*CW +: CW]
//   gate_len   - window length in clk cycles, 0 disables measurement
//   freq_min   - inclusive lower frequency limit, shared by all channels
//   freq_max   - inclusive upper frequency limit, shared by all channels
//   sticky_clr - per-channel clear of lost
//   toggling   - counter changed within the last HIST samples
//   lost       - sticky, set on a falling edge of toggling
//   freq       - increments counted in the last completed window, FW per channel
//   freq_valid - one-cycle pulse when freq updates
//   in_range   - freq_min <= freq <= freq_max for the last window
module clk_activity_monitor #(
  parameter int NCH  = 4,
  parameter int CW   = 4,
  parameter int HIST = 8,
  parameter int GW   = 16,
  parameter int FW   = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NCH*CW-1:0]   cnt_in,
  input  logic [GW-1:0]       gate_len,
  input  logic [FW-1:0]       freq_min,
  input  logic [FW-1:0]       freq_max,
  input  logic [NCH-1:0]      sticky_clr,
  output logic [NCH-1:0]      toggling,
  output logic [NCH-1:0]      lost,
  output logic [NCH*FW-1:0]   freq,
  output logic                freq_valid,
  output logic [NCH-1:0]      in_range
);

  localparam logic [GW-1:0] GW_ZERO = {GW{1'b0}};
  localparam logic [GW-1:0] GW_ONE  = {{(GW-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } gate_state_t;

  // Saturating accumulate: the window count pins at all-ones instead of
  // wrapping, so a too-fast clock still reads as out of range.
  function automatic logic [FW-1:0] sat_add(input logic [FW-1:0] a,
                                            input logic [CW-1:0] d);
    logic [FW:0] sum;
    sum = {1'b0, a} + {{(FW+1-CW){1'b0}}, d};
    if (sum[FW]) begin
      return {FW{1'b1}};
    end else begin
      return sum[FW-1:0];
    end
  endfunction

  // Inclusive limit check; an inverted pair (lo > hi) naturally yields 0.
  function automatic logic in_lim(input logic [FW-1:0] f,
                                  input logic [FW-1:0] lo,
                                  input logic [FW-1:0] hi);
    return (f >= lo) && (f <= hi);
  endfunction

  gate_state_t     state_r;
  gate_state_t     state_nxt_s;
  logic [GW-1:0]   timer_r;
  logic [GW-1:0]   len_r;
  logic [GW-1:0]   eff_len_s;
  logic [GW-1:0]   eff_last_s;
  logic            win_start_s;
  logic            acc_en_s;
  logic            win_end_s;

  logic            primed_r;
  logic [CW-1:0]   cnt_prev_r [NCH];
  logic [CW-1:0]   delta_s    [NCH];
  logic [NCH-1:0]  chg_r;
  logic [HIST-1:0] hist_r     [NCH];
  logic [HIST-1:0] hist_nxt_s [NCH];
  logic [NCH-1:0]  toggling_r;
  logic [NCH-1:0]  toggling_d_r;
  logic [NCH-1:0]  lost_r;
  logic [FW-1:0]   acc_r      [NCH];
  logic [FW-1:0]   acc_sum_s  [NCH];
  logic [FW-1:0]   freq_r     [NCH];
  logic            freq_valid_r;
  logic [NCH-1:0]  in_range_r;

  // gate_len is only honoured at window start; later in the window the copy
  // captured at start (len_r) governs, so mid-window edits wait a window.
  assign win_start_s = (timer_r == GW_ZERO);
  assign eff_len_s   = win_start_s ? gate_len : len_r;
  assign eff_last_s  = eff_len_s - GW_ONE;

  // Per-channel modular delta; forced to zero until the first sample after
  // reset has been captured so stale cnt_prev cannot produce a fake count.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      delta_s[i] = {CW{1'b0}};
      if (primed_r) begin
        delta_s[i] = cnt_in[i*CW +: CW] - cnt_prev_r[i];
      end else begin
        delta_s[i] = {CW{1'b0}};
      end
    end
  end

  // Next history vector and next accumulator value per channel.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      hist_nxt_s[i] = (hist_r[i] << 1'b1) | HIST'(chg_r[i]);
      acc_sum_s[i]  = sat_add(acc_r[i], delta_s[i]);
    end
  end

  // Gate FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Gate FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (gate_len != GW_ZERO) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (win_start_s && (gate_len == GW_ZERO)) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Gate FSM outputs: accumulate enable and end-of-window strobe.
  always_comb begin
    acc_en_s  = 1'b0;
    win_end_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        acc_en_s  = 1'b0;
        win_end_s = 1'b0;
      end
      ST_RUN: begin
        if (win_start_s && (gate_len == GW_ZERO)) begin
          acc_en_s  = 1'b0;
          win_end_s = 1'b0;
        end else begin
          acc_en_s  = 1'b1;
          win_end_s = (timer_r == eff_last_s);
        end
      end
      default: begin
        acc_en_s  = 1'b0;
        win_end_s = 1'b0;
      end
    endcase
  end

  // Window timer and captured window length.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_r <= GW_ZERO;
      len_r   <= GW_ZERO;
    end else begin
      if (!acc_en_s || win_end_s) begin
        timer_r <= GW_ZERO;
      end else begin
        timer_r <= timer_r + GW_ONE;
      end
      if (acc_en_s && win_start_s) begin
        len_r <= gate_len;
      end
    end
  end

  // Prime flag and previous-sample capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      primed_r <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        cnt_prev_r[i] <= {CW{1'b0}};
      end
    end else begin
      primed_r <= 1'b1;
      for (int i = 0; i < NCH; i++) begin
        cnt_prev_r[i] <= cnt_in[i*CW +: CW];
      end
    end
  end

  // Change detect, toggle history and registered toggling flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      chg_r        <= {NCH{1'b0}};
      toggling_r   <= {NCH{1'b0}};
      toggling_d_r <= {NCH{1'b0}};
      for (int i = 0; i < NCH; i++) begin
        hist_r[i] <= {HIST{1'b0}};
      end
    end else begin
      toggling_d_r <= toggling_r;
      for (int i = 0; i < NCH; i++) begin
        chg_r[i]      <= (delta_s[i] != {CW{1'b0}});
        hist_r[i]     <= hist_nxt_s[i];
        toggling_r[i] <= |hist_r[i];
      end
    end
  end

  // Sticky loss flag; a new loss beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      lost_r <= {NCH{1'b0}};
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (toggling_d_r[i] && !toggling_r[i]) begin
          lost_r[i] <= 1'b1;
        end else if (sticky_clr[i]) begin
          lost_r[i] <= 1'b0;
        end
      end
    end
  end

  // Window accumulators, held at zero outside an active window.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        acc_r[i] <= {FW{1'b0}};
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (!acc_en_s || win_end_s) begin
          acc_r[i] <= {FW{1'b0}};
        end else begin
          acc_r[i] <= acc_sum_s[i];
        end
      end
    end
  end

  // Result registers: the last sample of the window is folded in directly,
  // and the limit check uses that new count rather than the previous one.
  always_ff @(posedge clk) begin
    if (rst) begin
      freq_valid_r <= 1'b0;
      in_range_r   <= {NCH{1'b0}};
      for (int i = 0; i < NCH; i++) begin
        freq_r[i] <= {FW{1'b0}};
      end
    end else begin
      freq_valid_r <= win_end_s;
      if (win_end_s) begin
        for (int i = 0; i < NCH; i++) begin
          freq_r[i]     <= acc_sum_s[i];
          in_range_r[i] <= in_lim(acc_sum_s[i], freq_min, freq_max);
        end
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_pack
    assign freq[g*FW +: FW] = freq_r[g];
  end

  assign toggling   = toggling_r;
  assign lost       = lost_r;
  assign freq_valid = freq_valid_r;
  assign in_range   = in_range_r;

endmodule

// File: tb/tb_clk_activity_monitor.sv
// Self-checking bench for clk_activity_monitor. Two instances share stimulus:
// the default build (FW=20) and a narrow FW=8 build used for saturation.
// Expected window results are pushed to a scoreboard queue when the
// stimulus is set up and popped when freq_valid is seen.
module tb_clk_activity_monitor;

  localparam int NCH = 4;
  localparam int CW  = 4;
  localparam int GW  = 16;
  localparam int FW  = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cnt_in;
  logic [15:0] gate_len;
  logic [19:0] freq_min;
  logic [19:0] freq_max;
  logic [7:0]  min8;
  logic [7:0]  max8;
  logic [3:0]  sticky_clr;

  logic [3:0]  toggling, lost, in_range;
  logic [79:0] freq;
  logic        freq_valid;
  logic [3:0]  toggling8, lost8, in_range8;
  logic [31:0] freq8;
  logic        freq_valid8;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [3:0] c0, c1, c2, c3;
  bit inc_on;

  typedef struct {
    logic [79:0] f;
    logic [31:0] f8;
    logic [3:0]  rng;
    logic [3:0]  rng8;
    int          at;
  } exp_t;
  exp_t sb[$];

  clk_activity_monitor #(.NCH(NCH), .CW(CW), .HIST(8), .GW(GW), .FW(FW)) dut (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .gate_len(gate_len),
    .freq_min(freq_min), .freq_max(freq_max), .sticky_clr(sticky_clr),
    .toggling(toggling), .lost(lost), .freq(freq),
    .freq_valid(freq_valid), .in_range(in_range)
  );

  clk_activity_monitor #(.NCH(NCH), .CW(CW), .HIST(8), .GW(GW), .FW(8)) dut8 (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .gate_len(gate_len),
    .freq_min(min8), .freq_max(max8), .sticky_clr(sticky_clr),
    .toggling(toggling8), .lost(lost8), .freq(freq8),
    .freq_valid(freq_valid8), .in_range(in_range8)
  );

  always #5 clk = ~clk;

  function automatic logic [79:0] pk(input int a0, input int a1, input int a2, input int a3);
    return {20'(a3), 20'(a2), 20'(a1), 20'(a0)};
  endfunction

  function automatic logic [7:0] s8(input int a);
    return (a > 255) ? 8'hFF : 8'(a);
  endfunction

  function automatic logic [31:0] pk8(input int a0, input int a1, input int a2, input int a3);
    return {s8(a3), s8(a2), s8(a1), s8(a0)};
  endfunction

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of counters, then sample 1 time unit after the edge.
  task automatic tick();
    if (inc_on) begin
      c1 += 4'd3;
      c2 += 4'd15;
    end
    cnt_in = {c3, c2, c1, c0};
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push(input logic [79:0] f, input logic [31:0] f8,
                      input logic [3:0] rng, input logic [3:0] rng8, input int at);
    exp_t e;
    e.f = f; e.f8 = f8; e.rng = rng; e.rng8 = rng8; e.at = at;
    sb.push_back(e);
  endtask

  // Wait (bounded) for the next freq_valid and compare against the scoreboard.
  task automatic wait_valid(input string tag, input int budget);
    exp_t e;
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (freq_valid !== 1'b1 && n < budget);
    if (sb.size() == 0) begin
      check({tag, "_sb_underflow"}, 80'd1, 80'd0);
      return;
    end
    e = sb.pop_front();
    if (freq_valid !== 1'b1) begin
      check({tag, "_timeout"}, 80'(freq_valid), 80'd1);
      return;
    end
    check({tag, "_at"}, 80'(cyc), 80'(e.at));
    check({tag, "_freq"}, freq, e.f);
    check({tag, "_freq8"}, 80'(freq8), 80'(e.f8));
    check({tag, "_range"}, 80'(in_range), 80'(e.rng));
    check({tag, "_range8"}, 80'(in_range8), 80'(e.rng8));
    check({tag, "_valid8"}, 80'(freq_valid8), 80'd1);
  endtask

  // Run n cycles expecting no freq_valid and a held freq.
  task automatic idle_ticks(input string tag, input int n, input logic [79:0] hold_f);
    int pulses;
    pulses = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (freq_valid === 1'b1 || freq_valid8 === 1'b1) pulses++;
    end
    check({tag, "_no_valid"}, 80'(pulses), 80'd0);
    check({tag, "_freq_hold"}, freq, hold_f);
  endtask

  initial begin
    int t0;
    rst = 1'b1; c0 = 4'hA; c1 = 4'hA; c2 = 4'hA; c3 = 4'hA;
    cnt_in = 16'hAAAA; gate_len = 16'd0; freq_min = 20'd0; freq_max = 20'd10;
    min8 = 8'd0; max8 = 8'hFF; sticky_clr = 4'd0; inc_on = 1'b0;
    repeat (3) tick();

    // Reset state.
    check("rst_toggling", 80'(toggling), 80'd0);
    check("rst_lost", 80'(lost), 80'd0);
    check("rst_freq", freq, 80'd0);
    check("rst_valid", 80'(freq_valid), 80'd0);
    check("rst_range", 80'(in_range), 80'd0);

    // Prime: counters held at A through reset must not count or toggle.
    rst = 1'b0; gate_len = 16'd16;
    push(pk(0, 0, 0, 0), pk8(0, 0, 0, 0), 4'hF, 4'hF, cyc + 17);
    repeat (5) tick();
    check("prime_toggling", 80'(toggling), 80'd0);
    wait_valid("prime", 20);
    gate_len = 16'd0;
    check("prime_lost", 80'(lost), 80'd0);

    // Toggle detect on ch0: 20 increments, then stop.
    for (int i = 0; i < 20; i++) begin
      c0 = c0 + 4'd1;
      tick();
      if (i == 1) check("tog_rise_early", 80'(toggling), 80'd0);
      if (i == 2) check("tog_rise", 80'(toggling), 80'h1);
    end
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 9) check("tog_hold", 80'(toggling), 80'h1);
      if (k == 10) begin
        check("tog_fall", 80'(toggling), 80'd0);
        check("lost_not_yet", 80'(lost), 80'd0);
      end
      if (k == 11) begin
        check("lost_set", 80'(lost), 80'h1);
        check("lost8_set", 80'(lost8), 80'h1);
        check("tog8_fall", 80'(toggling8), 80'd0);
      end
    end
    sticky_clr = 4'b0001;
    tick();
    sticky_clr = 4'b0000;
    check("lost_clear", 80'(lost), 80'd0);

    // Sticky priority: clear lands on the same edge the loss sets.
    c0 = c0 + 4'd1;
    tick();
    repeat (9) tick();
    check("prio_tog_hold", 80'(toggling), 80'h1);
    tick();
    check("prio_tog_fall", 80'(toggling), 80'd0);
    sticky_clr = 4'b0001;
    tick();
    check("prio_set_wins", 80'(lost), 80'h1);
    tick();
    check("prio_clr_next", 80'(lost), 80'd0);
    sticky_clr = 4'b0000;

    // Frequency with wrap (ch1 +3) and saturation in the FW=8 build (ch2 +15).
    freq_min = 20'd290; freq_max = 20'd310;
    c1 = 4'd9; inc_on = 1'b1; gate_len = 16'd100;
    t0 = cyc;
    push(pk(0, 100*3, 100*15, 0), pk8(0, 100*3, 100*15, 0), 4'b0010, 4'hF, t0 + 101);
    wait_valid("win1", 110);
    freq_max = 20'd299;
    push(pk(0, 100*3, 100*15, 0), pk8(0, 100*3, 100*15, 0), 4'b0000, 4'hF, t0 + 201);
    repeat (30) tick();
    gate_len = 16'd50;
    push(pk(0, 50*3, 50*15, 0), pk8(0, 50*3, 50*15, 0), 4'b0000, 4'hF, t0 + 251);
    wait_valid("win2", 80);
    wait_valid("win3", 60);

    // Gate disabled: back to IDLE, freq holds.
    gate_len = 16'd0;
    idle_ticks("gate_off", 120, pk(0, 50*3, 50*15, 0));

    // Minimum window: freq_valid every cycle in RUN.
    freq_min = 20'd0; freq_max = 20'd3; gate_len = 16'd1;
    t0 = cyc;
    for (int k = 2; k <= 4; k++) begin
      push(pk(0, 3, 15, 0), pk8(0, 3, 15, 0), 4'b1011, 4'hF, t0 + k);
    end
    wait_valid("min1", 5);
    wait_valid("min2", 5);
    wait_valid("min3", 5);
    gate_len = 16'd0;
    idle_ticks("min_off", 5, pk(0, 3, 15, 0));

    // Reset mid-window: window discarded, no pulse.
    gate_len = 16'd100;
    repeat (40) tick();
    rst = 1'b1; gate_len = 16'd0;
    tick();
    tick();
    check("rstmid_valid", 80'(freq_valid), 80'd0);
    check("rstmid_freq", freq, 80'd0);
    rst = 1'b0;
    idle_ticks("rstmid", 80, 80'd0);

    check("sb_empty", 80'(sb.size()), 80'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
